output_wrapper_cntrlr: RTL and testbench

- Sequences the output side of the compute wrapper.
- On the core's done pulse it loads the result into the output buffer. It then presents the result to the downstream consumer one word at a time, using a four-phase output_rdy/output_acc handshake.
- When the last word has been handed off, it raises outsent. The input wrapper controller uses outsent to release the next start.

---
 rtl/output_wrapper_cntrlr_pkg.sv | 15 +
 rtl/output_wrapper_cntrlr_word_counter.sv | 27 ++
 rtl/output_wrapper_cntrlr.sv | 96 +++++++++
 tb/tb_output_wrapper_cntrlr.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/output_wrapper_cntrlr_pkg.sv
// Shared definitions for the compute-wrapper controllers.
package output_wrapper_cntrlr_pkg;

    // Output-side sequencing states; all four 2-bit codes are used.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Words per result; the input and output wrappers must use the same value.
    localparam int unsigned DEFAULT_NUM_WORDS = 4;

endpackage

// File: rtl/output_wrapper_cntrlr_word_counter.sv
// Word counter with clear and increment, flagging the last word of a result.
module output_wrapper_cntrlr_word_counter #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Clear wins over increment; the controller never increments past the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(NUM_WORDS - 1));

endmodule

// File: rtl/output_wrapper_cntrlr.sv
// Output-side controller: loads the core result on done, then hands words
// downstream with a four-phase output_rdy/output_acc handshake.
module output_wrapper_cntrlr
    import output_wrapper_cntrlr_pkg::*;
#(
    parameter int unsigned NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int unsigned CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done,
    input  logic             output_acc,
    output logic             ld_buf,
    output logic [CNT_W-1:0] sel,
    output logic             output_rdy,
    output logic             outsent,
    output logic             busy,
    output logic             ovf
);

    state_t           state;
    state_t           next_state;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt;

    output_wrapper_cntrlr_word_counter #(
        .NUM_WORDS (NUM_WORDS),
        .CNT_W     (CNT_W)
    ) u_word_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    assign sel = cnt;

    // Next-state and counter control for the handshake sequence.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            EMPTY: begin
                if (done) next_state = LOAD;
            end
            LOAD: begin
                cnt_clear  = 1'b1;
                next_state = PRESENT;
            end
            PRESENT: begin
                if (output_acc) next_state = RELEASE;
            end
            RELEASE: begin
                if (!output_acc) begin
                    if (cnt_last) begin
                        cnt_clear  = 1'b1;
                        next_state = EMPTY;
                    end else begin
                        cnt_inc    = 1'b1;
                        next_state = PRESENT;
                    end
                end
            end
            default: begin
                cnt_clear  = 1'b0 | 1'b1;
                next_state = EMPTY;
            end
        endcase
    end

    // State register with outputs decoded from the next state, so each
    // registered output equals the Moore decode of the state it accompanies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            ld_buf     <= 1'b0;
            output_rdy <= 1'b0;
            busy       <= 1'b0;
            outsent    <= 1'b1;
            ovf        <= 1'b0;
        end else begin
            state      <= next_state;
            ld_buf     <= (next_state == LOAD);
            output_rdy <= (next_state == PRESENT);
            busy       <= (next_state != EMPTY);
            outsent    <= (next_state == EMPTY);
            if (done && (state != EMPTY)) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_output_wrapper_cntrlr.sv
// Directed bench for output_wrapper_cntrlr at NUM_WORDS = 4, 2 and 16.
module tb_output_wrapper_cntrlr;

    logic       clk;
    logic       rst;
    logic       done_a    [3];
    logic       acc_a     [3];
    logic       ld_a      [3];
    logic       rdy_a     [3];
    logic       outsent_a [3];
    logic       busy_a    [3];
    logic       ovf_a     [3];
    logic [3:0] sel_a     [3];
    logic [1:0] sel0;
    logic [0:0] sel1;
    logic [3:0] sel2;

    int n_checks = 0;
    int n_pass   = 0;

    assign sel_a[0] = {2'b00, sel0};
    assign sel_a[1] = {3'b000, sel1};
    assign sel_a[2] = sel2;

    output_wrapper_cntrlr #(.NUM_WORDS(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst), .done(done_a[0]), .output_acc(acc_a[0]),
        .ld_buf(ld_a[0]), .sel(sel0), .output_rdy(rdy_a[0]),
        .outsent(outsent_a[0]), .busy(busy_a[0]), .ovf(ovf_a[0])
    );

    output_wrapper_cntrlr #(.NUM_WORDS(2), .CNT_W(1)) dut2 (
        .clk(clk), .rst(rst), .done(done_a[1]), .output_acc(acc_a[1]),
        .ld_buf(ld_a[1]), .sel(sel1), .output_rdy(rdy_a[1]),
        .outsent(outsent_a[1]), .busy(busy_a[1]), .ovf(ovf_a[1])
    );

    output_wrapper_cntrlr #(.NUM_WORDS(16), .CNT_W(4)) dut16 (
        .clk(clk), .rst(rst), .done(done_a[2]), .output_acc(acc_a[2]),
        .ld_buf(ld_a[2]), .sel(sel2), .output_rdy(rdy_a[2]),
        .outsent(outsent_a[2]), .busy(busy_a[2]), .ovf(ovf_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One result on instance i with n words. Word slow_w keeps the ack high for
    // hold cycles. dup_w selects where a second done is injected: a word index
    // (alongside that word's ack) or n (on the final ack drop); -1 means none.
    task automatic transfer(input int i, input int n, input int slow_w, input int hold,
                            input int dup_w, input int ovf_before);
        int ovf_exp;
        ovf_exp = ovf_before;
        done_a[i] = 1'b1;
        tick();
        done_a[i] = 1'b0;
        check("load_ld_buf", ld_a[i], 1);
        check("load_busy", busy_a[i], 1);
        check("load_outsent", outsent_a[i], 0);
        check("load_rdy", rdy_a[i], 0);
        for (int w = 0; w < n; w++) begin
            tick();
            check("present_rdy", rdy_a[i], 1);
            check("present_sel", sel_a[i], w);
            check("present_ld_buf", ld_a[i], 0);
            check("present_busy", busy_a[i], 1);
            acc_a[i] = 1'b1;
            if (dup_w == w) done_a[i] = 1'b1;
            tick();
            done_a[i] = 1'b0;
            if (dup_w == w) ovf_exp = 1;
            check("release_rdy", rdy_a[i], 0);
            check("release_sel", sel_a[i], w);
            check("release_ovf", ovf_a[i], ovf_exp);
            if (w == slow_w) begin
                for (int h = 1; h < hold; h++) begin
                    tick();
                    check("hold_sel", sel_a[i], w);
                    check("hold_rdy", rdy_a[i], 0);
                    check("hold_busy", busy_a[i], 1);
                end
            end
            acc_a[i] = 1'b0;
            if (dup_w == n && w == n - 1) done_a[i] = 1'b1;
        end
        tick();
        done_a[i] = 1'b0;
        if (dup_w == n) ovf_exp = 1;
        check("end_outsent", outsent_a[i], 1);
        check("end_busy", busy_a[i], 0);
        check("end_rdy", rdy_a[i], 0);
        check("end_sel", sel_a[i], 0);
        check("end_ld_buf", ld_a[i], 0);
        check("end_ovf", ovf_a[i], ovf_exp);
        tick();
        check("idle_ld_buf", ld_a[i], 0);
        check("idle_outsent", outsent_a[i], 1);
        check("idle_ovf", ovf_a[i], ovf_exp);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            done_a[i] = 1'b0;
            acc_a[i]  = 1'b0;
        end
        #3;
        for (int i = 0; i < 3; i++) begin
            check("rst_outsent", outsent_a[i], 1);
            check("rst_busy", busy_a[i], 0);
            check("rst_ld_buf", ld_a[i], 0);
            check("rst_rdy", rdy_a[i], 0);
            check("rst_sel", sel_a[i], 0);
            check("rst_ovf", ovf_a[i], 0);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_after_rst", outsent_a[0], 1);

        // Fastest path, then a slow consumer on word 1.
        transfer(0, 4, -1, 0, -1, 0);
        transfer(0, 4, 1, 5, -1, 0);

        // Second done while word 2 is presented: sticky overflow, no reload.
        transfer(0, 4, -1, 0, 2, 0);
        tick();
        tick();
        check("ovf_sticky", ovf_a[0], 1);

        // Reset in PRESENT with sel = 2.
        done_a[0] = 1'b1;
        tick();
        done_a[0] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            tick();
            acc_a[0] = 1'b1;
            tick();
            acc_a[0] = 1'b0;
        end
        tick();
        check("mid_sel", sel_a[0], 2);
        check("mid_rdy", rdy_a[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_outsent", outsent_a[0], 1);
        check("async_rdy", rdy_a[0], 0);
        check("async_sel", sel_a[0], 0);
        check("async_busy", busy_a[0], 0);
        check("async_ovf", ovf_a[0], 0);
        tick();
        rst = 1'b0;
        tick();
        transfer(0, 4, -1, 0, -1, 0);

        // Word-count extremes, plus done coinciding with the return to EMPTY.
        transfer(1, 2, -1, 0, -1, 0);
        transfer(2, 16, 7, 3, -1, 0);
        transfer(1, 2, -1, 0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
